// File: rtl/pulse_sync_fast.sv
// Fast-domain receiver for a slow/asynchronous request level: synchronize, qualify, one-shot pulse, 4-phase ack.
// Optional macro PULSE_SYNC_STRETCH_EN stretches the pulse to PULSE_W cycles (default build: 1-cycle pulse).
module pulse_sync_fast #(
    parameter int SYNC_STAGES = 2,
    parameter int QUAL_CYCLES = 4,
    parameter int HOLDOFF     = 3,
    parameter int PULSE_W     = 4
) (
    input  logic       fast_clk,
    input  logic       clr_n,
    input  logic       level_in,
    input  logic       enable,
    output logic       pulse_out,
    output logic       ack_out,
    output logic       busy,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        QUAL  = 3'd1,
        PULSE = 3'd2,
        ACKW  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [7:0] QUAL_LAST = 8'(QUAL_CYCLES);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || QUAL_CYCLES < 1 || QUAL_CYCLES > 255 ||
            HOLDOFF < 0 || HOLDOFF > 255 || PULSE_W < 1 || PULSE_W > 255) begin : g_bad_params
            $error("pulse_sync_fast: parameter out of legal range");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [7:0]             qcnt_q;
    logic [7:0]             hcnt_q;
    logic                   pulse_q;
    logic                   ack_q;
    logic                   busy_q;
    logic [7:0]             glitch_q;
`ifdef PULSE_SYNC_STRETCH_EN
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_W);
    logic [7:0]             wcnt_q;
`endif

    always_ff @(posedge fast_clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Outputs are updated together with the state so each one comes straight from a flop.
    always_ff @(posedge fast_clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            qcnt_q   <= '0;
            hcnt_q   <= '0;
            pulse_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
`ifdef PULSE_SYNC_STRETCH_EN
            wcnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && s) begin
                        state_q <= QUAL;
                        qcnt_q  <= 8'd1;
                        busy_q  <= 1'b1;
                    end
                end
                QUAL: begin
                    if (!s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (glitch_q != 8'hFF) begin
                            glitch_q <= glitch_q + 8'd1;
                        end
                    end else if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (qcnt_q == QUAL_LAST) begin
                        state_q <= PULSE;
                        pulse_q <= 1'b1;
                        ack_q   <= 1'b1;
`ifdef PULSE_SYNC_STRETCH_EN
                        wcnt_q  <= 8'd1;
`endif
                    end else begin
                        qcnt_q <= qcnt_q + 8'd1;
                    end
                end
                PULSE: begin
`ifdef PULSE_SYNC_STRETCH_EN
                    // Width is fixed once accepted; s dropping mid-pulse does not shorten it.
                    if (wcnt_q == PULSE_LAST) begin
                        state_q <= ACKW;
                        pulse_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
`else
                    state_q <= ACKW;
                    pulse_q <= 1'b0;
`endif
                end
                ACKW: begin
                    if (!s) begin
                        ack_q <= 1'b0;
                        if (HOLDOFF == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                            hcnt_q  <= 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (hcnt_q == HOLD_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pulse_q <= 1'b0;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out  = pulse_q;
    assign ack_out    = ack_q;
    assign busy       = busy_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_pulse_sync_fast.sv
// Directed self-checking bench for pulse_sync_fast with default parameters.
module tb_pulse_sync_fast;

    logic       fast_clk = 1'b0;
    logic       clr_n    = 1'b1;
    logic       level_in = 1'b0;
    logic       enable   = 1'b1;
    logic       pulse_out;
    logic       ack_out;
    logic       busy;
    logic [7:0] glitch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PULSE_SYNC_STRETCH_EN
    localparam int PULSE_LAST_J = 3;
    localparam int ACK_LAST_J   = 4;
    localparam int BUSY_LAST_J  = 7;
`else
    localparam int PULSE_LAST_J = 0;
    localparam int ACK_LAST_J   = 2;
    localparam int BUSY_LAST_J  = 5;
`endif

    pulse_sync_fast dut (
        .fast_clk   (fast_clk),
        .clr_n      (clr_n),
        .level_in   (level_in),
        .enable     (enable),
        .pulse_out  (pulse_out),
        .ack_out    (ack_out),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic apply_reset();
        clr_n    = 1'b0;
        level_in = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [10:0] got;
        clr_n = 1'b0;
        #1;
        got = {pulse_out, ack_out, busy, glitch_cnt};
        n_cmp++;
        if (got !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_async: outputs=%h expected 000", got);
        end
        tick();
        tick();
        clr_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = {pulse_out, ack_out, busy, glitch_cnt};
            n_cmp++;
            if (got !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d: outputs=%h expected 000", k, got);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [2:0] exp;
        logic [2:0] got;
        enable = 1'b1;
        apply_reset();
        level_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {k == 7, k >= 7, k >= 3};
            got = {pulse_out, ack_out, busy};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL basic_high k=%0d: pulse/ack/busy=%b expected %b", k, got, exp);
            end
        end
        level_in = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp = {1'b0, j <= 2, j <= 5};
            got = {pulse_out, ack_out, busy};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL basic_low j=%0d: pulse/ack/busy=%b expected %b", j, got, exp);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_glitch();
        logic       seen;
        logic [7:0] exp;
        enable = 1'b1;
        apply_reset();
        seen = 1'b0;
        for (int r = 0; r < 300; r++) begin
            level_in = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                seen |= pulse_out;
            end
            level_in = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                seen |= pulse_out;
            end
            exp = (r + 1 > 255) ? 8'd255 : 8'(r + 1);
            n_cmp++;
            if (glitch_cnt !== exp) begin
                n_bad++;
                $display("FAIL glitch_cnt rep=%0d: got %0d expected %0d", r, glitch_cnt, exp);
            end
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_pulse: pulse_out seen=%b expected 0", seen);
        end
        $display("test_glitch done glitch_cnt=%0d", glitch_cnt);
    endtask

    task automatic test_back_to_back();
        int cnt;
        int first;
        enable = 1'b1;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            cnt   = 0;
            first = 0;
            level_in = 1'b1;
            for (int k = 1; k <= ((pass == 0) ? 100 : 20); k++) begin
                tick();
                if (pulse_out === 1'b1) begin
                    cnt++;
                    if (first == 0) first = k;
                end
            end
            n_cmp++;
            if (cnt != 1 || first != 7) begin
                n_bad++;
                $display("FAIL b2b_pulse pass=%0d: count=%0d first=%0d expected count=1 first=7", pass, cnt, first);
            end
            level_in = 1'b0;
            for (int j = 0; j < 10; j++) tick();
            n_cmp++;
            if ({ack_out, busy} !== 2'b00) begin
                n_bad++;
                $display("FAIL b2b_idle pass=%0d: ack/busy=%b expected 00", pass, {ack_out, busy});
            end
            $display("test_back_to_back pass=%0d count=%0d first=%0d", pass, cnt, first);
        end
    endtask

    task automatic test_enable();
        logic any_act;
        enable = 1'b0;
        apply_reset();
        level_in = 1'b1;
        any_act  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            any_act |= pulse_out | busy | ack_out;
        end
        n_cmp++;
        if (any_act !== 1'b0 || glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL enable_off: activity=%b glitch=%0d expected 0 0", any_act, glitch_cnt);
        end
        enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if (pulse_out !== (k == 5)) begin
                n_bad++;
                $display("FAIL enable_rise k=%0d: pulse_out=%b expected %b", k, pulse_out, k == 5);
            end
        end
        level_in = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        level_in = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL enable_qual: busy=%b expected 1", busy);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_abort: busy=%b expected 0", busy);
        end
        any_act = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            any_act |= pulse_out | busy | ack_out;
        end
        n_cmp++;
        if (any_act !== 1'b0 || glitch_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL enable_after_abort: activity=%b glitch=%0d expected 0 0", any_act, glitch_cnt);
        end
        level_in = 1'b0;
        enable   = 1'b1;
        $display("test_enable done");
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        logic        any_act;
        enable = 1'b1;
        apply_reset();
        level_in = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        n_cmp++;
        if ({pulse_out, ack_out, busy} !== 3'b111) begin
            n_bad++;
            $display("FAIL mid_before: pulse/ack/busy=%b expected 111", {pulse_out, ack_out, busy});
        end
        #2;
        clr_n = 1'b0;
        #1;
        got = {pulse_out, ack_out, busy, glitch_cnt};
        n_cmp++;
        if (got !== 11'd0) begin
            n_bad++;
            $display("FAIL mid_clear: outputs=%h expected 000", got);
        end
        level_in = 1'b0;
        tick();
        tick();
        clr_n   = 1'b1;
        any_act = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            any_act |= pulse_out | ack_out | busy;
        end
        n_cmp++;
        if (any_act !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_release: activity=%b expected 0", any_act);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_stretch();
        logic [2:0] exp;
        logic [2:0] got;
        enable = 1'b1;
        apply_reset();
        level_in = 1'b1;
        for (int k = 1; k <= 7; k++) tick();
        n_cmp++;
        if ({pulse_out, ack_out} !== 2'b11) begin
            n_bad++;
            $display("FAIL stretch_start: pulse/ack=%b expected 11", {pulse_out, ack_out});
        end
        level_in = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            exp = {j <= PULSE_LAST_J, j <= ACK_LAST_J, j <= BUSY_LAST_J};
            got = {pulse_out, ack_out, busy};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL stretch j=%0d: pulse/ack/busy=%b expected %b", j, got, exp);
            end
        end
        $display("test_stretch done");
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_glitch();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_stretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_sync_fast.md
Name: pulse_sync_fast

Overview:
Fast-domain receiver for a reset/strobe level driven from a slower or asynchronous domain. It synchronizes the level, qualifies it against glitches, and emits exactly one fast_clk pulse per accepted assertion. It returns a level acknowledge so the sender can drop its request (4-phase handshake), then re-arms after a hold-off. It sits on the fast side of slow-to-fast control crossings, such as reset and start strobes into fast datapaths.

Parameters:
SYNC_STAGES, 2, synchronizer flop count on level_in (legal 2..4)
QUAL_CYCLES, 4, required high-stability count before accept (legal 1..255)
HOLDOFF, 3, idle cycles after handshake completes before re-arm (legal 0..255)
PULSE_W, 4, pulse width in cycles; used only with PULSE_SYNC_STRETCH_EN (legal 1..255)

Ports:
fast_clk  input  1  sole clock; all flops rising-edge
clr_n  input  1  asynchronous active-low reset
level_in  input  1  request level, asynchronous to fast_clk
enable  input  1  synchronous accept enable
pulse_out  output  1  registered one-shot pulse in fast_clk domain
ack_out  output  1  registered acknowledge level back to sender
busy  output  1  high whenever FSM not in IDLE
glitch_cnt  output  8  saturating count of rejected (unqualified) assertions

Behaviour:
- Reset (clr_n low):
  - Async clear of sync chain, FSM (to IDLE) and all counters.
  - pulse_out=0, ack_out=0, busy=0, glitch_cnt=0 immediately, with no clock edge needed.
  - Applies mid-operation too; any pulse in progress is truncated.
- Synchronizer: level_in -> SYNC_STAGES flops; s = last stage. FSM uses only s.
- FSM states: IDLE, QUAL, PULSE, ACKW, HOLD. busy = (state != IDLE).
- IDLE:
  - enable=1 and s=1 -> QUAL, qcnt=1.
  - Level-sensitive: a level already high at reset release or enable rise is accepted.
- QUAL:
  - s=0 -> IDLE, glitch_cnt += 1, saturating at 255.
  - enable=0 -> IDLE, no glitch count.
  - s=1 and qcnt==QUAL_CYCLES -> PULSE.
  - Otherwise qcnt += 1.
  - Acceptance therefore needs s high on QUAL_CYCLES+1 consecutive FSM samples.
- Latency: pulse_out rises SYNC_STAGES+QUAL_CYCLES+1 edges after the first edge that samples level_in high (7 with defaults).
- PULSE:
  - pulse_out=1 for exactly 1 cycle, then -> ACKW.
  - ack_out=1 from PULSE entry.
- ACKW:
  - ack_out=1 while waiting.
  - s=0 -> HOLD, or directly to IDLE when HOLDOFF=0.
- HOLD:
  - ack_out=0; stays exactly HOLDOFF cycles, then -> IDLE.
  - level_in activity is ignored and not counted as a glitch.
  - If s is high on return to IDLE, a new qualification begins.
- enable=0 in PULSE/ACKW/HOLD does not abort; the handshake always completes.
- All outputs are registered; no combinational path from level_in or enable to any output.
- glitch_cnt: cleared only by clr_n; never wraps.

Optional Feature:
PULSE_SYNC_STRETCH_EN:
- Defined: PULSE lasts PULSE_W cycles using an 8-bit width counter; pulse_out stays high for all of them even if s drops mid-pulse; ack_out is asserted from PULSE entry as before.
- Undefined: PULSE_W is ignored, the width counter is not built, and the pulse is always 1 cycle.

Test Plan:
- Defaults, reset released, level_in high 20 cycles then low -> one pulse_out cycle 7 edges after first high sample. ack_out high from that edge until SYNC_STAGES+1 edges after level_in falls. busy low 3 cycles later.
- level_in high 3 cycles then low, repeated 300 times -> no pulse_out, glitch_cnt steps 1,2,… and holds at 255.
- level_in held high 100 cycles -> exactly one pulse. Drop for 10 cycles, raise again -> second pulse after 7 edges.
- enable=0 with level_in high 50 cycles -> no pulse, glitch_cnt=0. Raise enable -> pulse_out rises 5 edges later. Drop enable during QUAL on a later request -> IDLE, glitch_cnt unchanged.
- clr_n pulled low while ack_out=1 -> pulse_out, ack_out, busy read 0 before the next fast_clk edge. After release with level_in low, all outputs stay 0.
- PULSE_SYNC_STRETCH_EN, PULSE_W=4, level_in drops 1 cycle after pulse starts -> pulse_out high exactly 4 cycles, ack_out high exactly 5 cycles, then HOLD 3 cycles, busy low.
